mem_boot_loader: RTL and testbench

- Sits directly upstream of the 1024x8 program/data memory and owns its single write/read port.
- After reset it holds the 8051 core in reset and fills memory from a UART receive byte stream: a 2-byte length header, then payload.
- On completion it releases the core and passes the core's memory port through unchanged.
- Sends an 8-bit payload checksum back over UART (optional).

---
 rtl/mem_boot_loader.sv | 160 ++++++++++++++++
 tb/tb_mem_boot_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_loader.sv
// UART-fed boot loader: fills program memory from a length-prefixed byte stream, then releases the core.
// Latency: a byte is driven onto the memory port combinationally in its strobe cycle; no backpressure on rx. Optional checksum via MEM_BOOT_LOADER_ACK_EN.
module mem_boot_loader #(
    parameter int          ADDR_W  = 10,
    parameter int          DEPTH   = 1024,
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_reload,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_we,
    input  logic [7:0]        i_cpu_wdata,
    input  logic              i_cpu_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_re,
    output logic              o_cpu_rst,
    output logic              o_err,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_ready
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_ACK    = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   count_q;
    logic [7:0]        sum_q;
    logic [23:0]       timer_q;
    logic              err_q;

    logic [15:0]       hdr_len;
    logic              len_ok;
    logic              timer_on;
    logic              timeout_hit;
    logic              last_byte;

    assign hdr_len     = {i_rx_data, len_q[7:0]};
    assign len_ok      = (hdr_len != 16'd0) && (hdr_len <= 16'(DEPTH));
    assign timer_on    = (state_q == S_LEN_HI) || (state_q == S_DATA);
    // A byte arriving in the expiry cycle takes priority over the abort.
    assign timeout_hit = timer_on && !i_rx_valid && (timer_q == TIMEOUT - 24'd1);
    assign last_byte   = i_rx_valid && (16'(count_q) == len_q - 16'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN_LO: if (i_rx_valid) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (i_rx_valid)       state_d = len_ok ? S_DATA : S_LEN_LO;
                else if (timeout_hit) state_d = S_LEN_LO;
            end
            S_DATA: begin
                if (last_byte)        state_d = S_ACK;
                else if (timeout_hit) state_d = S_LEN_LO;
            end
`ifdef MEM_BOOT_LOADER_ACK_EN
            S_ACK:    if (i_tx_ready) state_d = S_RUN;
`else
            S_ACK:    state_d = S_RUN;
`endif
            S_RUN:    if (i_reload) state_d = S_LEN_LO;
            default:  state_d = S_LEN_LO;
        endcase
    end

    always_comb begin
        o_mem_addr  = count_q[ADDR_W-1:0];
        o_mem_we    = 1'b0;
        o_mem_wdata = 8'h00;
        o_mem_re    = 1'b0;
        if (state_q == S_RUN) begin
            o_mem_addr  = i_cpu_addr;
            o_mem_we    = i_cpu_we;
            o_mem_wdata = i_cpu_wdata;
            o_mem_re    = i_cpu_re;
        end else if (state_q == S_DATA && i_rx_valid) begin
            o_mem_we    = 1'b1;
            o_mem_wdata = i_rx_data;
        end
    end

    assign o_cpu_rst = (state_q != S_RUN);
    assign o_err     = err_q;

`ifdef MEM_BOOT_LOADER_ACK_EN
    assign o_tx_valid = (state_q == S_ACK);
    assign o_tx_data  = (state_q == S_ACK) ? sum_q : 8'h00;
`else
    logic unused_tx_ready;
    assign unused_tx_ready = i_tx_ready;
    assign o_tx_valid      = 1'b0;
    assign o_tx_data       = 8'h00;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!timer_on || i_rx_valid || timeout_hit) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 24'd1;
            end

            case (state_q)
                S_LEN_LO: if (i_rx_valid) len_q[7:0] <= i_rx_data;
                S_LEN_HI: begin
                    if (i_rx_valid) begin
                        len_q <= hdr_len;
                        if (len_ok) begin
                            count_q <= '0;
                            sum_q   <= '0;
                            err_q   <= 1'b0;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        count_q <= '0;
                    end
                end
                S_DATA: begin
                    if (i_rx_valid) begin
                        sum_q   <= sum_q + i_rx_data;
                        count_q <= count_q + 1'b1;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        count_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed + randomized bench for mem_boot_loader; a small memory captures the DUT's write port.
// Payloads are random; expected images and checksums come straight from the sent byte lists.
module tb_mem_boot_loader;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1024;
    localparam int          TMO_I = 40;
    localparam logic [23:0] TMO   = 24'd40;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          reload;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic [7:0]    cpu_wdata;
    logic          cpu_re;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic          mem_re;
    logic          cpu_rst;
    logic          err;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] bmem [0:DEPTH-1];
    logic [7:0] pl [$];

    mem_boot_loader #(.ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .i_reload   (reload),
        .i_cpu_addr (cpu_addr),
        .i_cpu_we   (cpu_we),
        .i_cpu_wdata(cpu_wdata),
        .i_cpu_re   (cpu_re),
        .o_mem_addr (mem_addr),
        .o_mem_we   (mem_we),
        .o_mem_wdata(mem_wdata),
        .o_mem_re   (mem_re),
        .o_cpu_rst  (cpu_rst),
        .o_err      (err),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .i_tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) bmem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic do_reload();
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b1;
        #1;
        chk("reload_same_cycle_rst", cpu_rst, 0);
        @(negedge clk);
        reload = 1'b0;
        #1;
        chk("reload_next_cycle_rst", cpu_rst, 1);
    endtask

    task automatic finish_ack(input logic [7:0] s);
`ifdef MEM_BOOT_LOADER_ACK_EN
        tx_ready = 1'b0;
        repeat (5) begin
            idle(1);
            chk("ack_tx_valid", tx_valid, 1);
            chk("ack_tx_data", tx_data, s);
            chk("ack_cpu_rst", cpu_rst, 1);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        #1;
        chk("ack_hs_valid", tx_valid, 1);
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_tx_valid", tx_valid, 0);
`else
        idle(1);
        chk("ack_cpu_rst", cpu_rst, 1);
        chk("ack_tx_valid", tx_valid, 0);
        chk("ack_sum_unused", {24'h0, s} & 32'h0, 0);
        idle(1);
        chk("run_cpu_rst", cpu_rst, 0);
`endif
    endtask

    // gap < 0: random idle gaps (up to the last safe cycle before timeout); otherwise fixed gap.
    task automatic run_frame(input int gap);
        int len;
        int g;
        logic [7:0] s;
        len = pl.size();
        s   = 8'h00;
        send(8'(len));
        chk("hdr_lo_no_we", mem_we, 0);
        send(8'(len >> 8));
        chk("hdr_hi_no_we", mem_we, 0);
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                if (gap < 0) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TMO_I - 1)) : 0;
                else         g = gap;
                if (g > 0) idle(g);
            end
            send(pl[i]);
            chk("data_we", mem_we, 1);
            chk("data_addr", mem_addr, i);
            chk("data_wdata", mem_wdata, pl[i]);
            if (i == 0) chk("hdr_ok_err", err, 0);
            s = s + pl[i];
        end
        finish_ack(s);
        for (int i = 0; i < len; i++) chk("mem_image", bmem[i], pl[i]);
    endtask

    task automatic rand_payload(input int len);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
        cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_re = 1'b1; tx_ready = 1'b0;

        do_reset(3);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_err", err, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // Basic 3-byte frame; checksum AA+55+01 wraps to 00.
        pl = '{8'hAA, 8'h55, 8'h01};
        run_frame(0);

        // RUN: core port passes straight through, rx bytes are ignored.
        @(negedge clk);
        cpu_addr = 10'h3FF; cpu_we = 1'b1; cpu_wdata = 8'hC3; cpu_re = 1'b0;
        #1;
        chk("run_mux_addr", mem_addr, 10'h3FF);
        chk("run_mux_we", mem_we, 1);
        chk("run_mux_wdata", mem_wdata, 8'hC3);
        chk("run_mux_re", mem_re, 0);
        @(negedge clk);
        cpu_addr = 10'h155; cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_re = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h99;
        #1;
        chk("run_rx_no_we", mem_we, 0);
        chk("run_mux_re1", mem_re, 1);
        chk("run_mux_addr2", mem_addr, 10'h155);
        chk("run_still_running", cpu_rst, 0);
        idle(2);
        chk("run_rx_ignored", cpu_rst, 0);
        chk("cpu_write_landed", bmem[10'h3FF], 8'hC3);

        do_reload();
        chk("load_re_masked", mem_re, 0);

        // Illegal lengths 1025 and 0 flag an error and wait for a new header.
        send(8'h01); send(8'h04);
        idle(1);
        chk("len1025_err", err, 1);
        chk("len1025_cpu_rst", cpu_rst, 1);
        chk("len1025_no_we", mem_we, 0);
        send(8'h00); send(8'h00);
        idle(1);
        chk("len0_err", err, 1);
        chk("len0_no_we", mem_we, 0);
        pl = '{8'h7E};
        run_frame(0);
        chk("after_bad_err", err, 0);

        // Timeout: one byte of a 4-byte frame, then silence.
        do_reload();
        send(8'h04); send(8'h00); send(8'h11);
        chk("to_first_we", mem_we, 1);
        chk("to_first_addr", mem_addr, 0);
        idle(TMO_I);
        chk("to_not_yet_err", err, 0);
        chk("to_idle_addr", mem_addr, 1);
        idle(1);
        chk("to_err", err, 1);
        chk("to_cpu_rst", cpu_rst, 1);
        chk("to_count_clr", mem_addr, 0);
        chk("to_partial_kept", bmem[0], 8'h11);
        rand_payload(1);
        run_frame(0);

        // A byte landing exactly in the expiry cycle still counts.
        do_reload();
        rand_payload(2);
        run_frame(TMO_I - 1);
        chk("edge_no_err", err, 0);

        // Reset mid-load keeps the partial image; LEN_LO never times out.
        do_reload();
        send(8'h08); send(8'h00);
        send(8'h21); send(8'h22); send(8'h23);
        do_reset(1);
        chk("midrst_cpu_rst", cpu_rst, 1);
        chk("midrst_err", err, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_mem0", bmem[0], 8'h21);
        chk("midrst_mem2", bmem[2], 8'h23);
        idle(TMO_I + 5);
        chk("lenlo_no_timeout", err, 0);

        // Randomized frames with random gaps.
        for (int f = 0; f < 3; f++) begin
            rand_payload(int'($urandom_range(1, 40)));
            run_frame(-1);
            do_reload();
        end

        // Full-depth back-to-back image; must end at 0x3FF without wrapping.
        rand_payload(DEPTH);
        run_frame(0);
        chk("full_last_word", bmem[10'h3FF], pl[DEPTH-1]);
        do_reload();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
